// File: rtl/spike_classifier.sv
// Spike-count classifier: accumulates per-neuron spikes over an image, then
// scans the counters sequentially and reports the argmax (ties -> lowest index).
module spike_classifier #(
    parameter int N_OUT = 10,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_OUT-1:0] spike_in,
    input  logic             spike_vld,
    input  logic             img_done,
    output logic [3:0]       class_id,
    output logic [CNT_W-1:0] max_count,
    output logic             class_vld,
    output logic             no_spike,
    output logic             busy,
    output logic             drop_err,
    output logic [1:0]       fsm_state
);

    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt [N_OUT];
    logic [IDX_W-1:0] scan_idx;
    logic [CNT_W-1:0] best_val;
    logic [IDX_W-1:0] best_idx;

    logic [CNT_W-1:0] cnt_k;
    logic             take;
    logic [CNT_W-1:0] best_val_nxt;
    logic [IDX_W-1:0] best_idx_nxt;
    logic             scan_last;
    logic             accum;

    assign accum     = (state == ACCUM);
    assign busy      = ~accum;
    assign class_vld = (state == DONE);
    assign fsm_state = state;

    // Strict greater-than keeps the earliest index on ties.
    assign cnt_k        = cnt[scan_idx];
    assign take         = (cnt_k > best_val);
    assign best_val_nxt = take ? cnt_k : best_val;
    assign best_idx_nxt = take ? scan_idx : best_idx;
    assign scan_last    = (scan_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (img_done) state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = DONE;
            DONE:    state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else if (state == DONE) begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else if (accum && spike_vld) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (spike_in[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Scan bookkeeping is re-primed every ACCUM cycle so SCAN always starts at 0/0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_idx <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
            best_val <= best_val_nxt;
            best_idx <= best_idx_nxt;
        end else begin
            scan_idx <= '0;
            best_val <= '0;
            best_idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            class_id  <= '0;
            max_count <= '0;
            no_spike  <= 1'b0;
        end else if ((state == SCAN) && scan_last) begin
            class_id  <= 4'(best_idx_nxt);
            max_count <= best_val_nxt;
            no_spike  <= (best_val_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_err <= 1'b0;
        end else if (busy && (spike_vld || img_done)) begin
            drop_err <= 1'b1;
        end
    end

endmodule

// File: doc/spike_classifier.md
SPIKE_CLASSIFIER -- requirements
Module: spike_classifier

Interface
REQ-001 Parameter N_OUT, default 10, number of output neurons (spike lanes) from the FC spiking layer.
REQ-002 Parameter CNT_W, default 6, width of each per-neuron spike counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 spike_in  input  N_OUT  per-neuron spike vector of one simulation time step from the FC layer.
REQ-006 spike_vld  input  1  spike_in is valid this cycle (one strobe per time step).
REQ-007 img_done  input  1  one-cycle pulse: last time step of current image delivered.
REQ-008 class_id  output  4  winning neuron index, held until next result.
REQ-009 max_count  output  CNT_W  spike count of the winner, held with class_id.
REQ-010 class_vld  output  1  one-cycle pulse: class_id/max_count/no_spike updated.
REQ-011 no_spike  output  1  winner count is zero (no neuron fired for the image).
REQ-012 busy  output  1  high while the block is not accepting spikes.
REQ-013 drop_err  output  1  sticky: input arrived while busy.

Function
REQ-014 The block SHALL implement states ACCUM, SCAN, DONE; busy SHALL equal (state != ACCUM).
REQ-015 In ACCUM, on spike_vld, each cnt[i] SHALL increment by spike_in[i], saturating at 2^CNT_W-1 (no wrap).
REQ-016 In ACCUM, img_done SHALL move the FSM to SCAN next cycle; a spike_vld in the same cycle SHALL be counted before the scan.
REQ-017 SCAN SHALL examine cnt[0]..cnt[N_OUT-1] one per cycle (N_OUT cycles), updating best index/value only when cnt[k] > best value (strict), so ties resolve to the lowest index.
REQ-018 Best value/index SHALL initialise to 0/0 on SCAN entry.
REQ-019 After the k=N_OUT-1 cycle the FSM SHALL enter DONE for exactly one cycle, asserting class_vld and loading class_id, max_count, no_spike (= best value==0).
REQ-020 In DONE all cnt[i] SHALL clear to 0; the FSM SHALL return to ACCUM next cycle.
REQ-021 Latency: img_done at cycle t SHALL give class_vld at cycle t+N_OUT+1 (t+11 at default); next spike_vld accepted at t+N_OUT+2.
REQ-022 spike_vld or img_done while busy SHALL be ignored (no count change, no restart) and SHALL set drop_err, which stays 1 until reset.
REQ-023 img_done with no prior spike_vld SHALL still run the scan and report class_id=0, max_count=0, no_spike=1.
REQ-024 class_id, max_count, no_spike SHALL hold their values between class_vld pulses.
REQ-025 Unused spike_in bits beyond N_OUT do not exist; class_id width 4 SHALL suffice for N_OUT<=16.

Reset
REQ-026 rst=0 SHALL asynchronously force state=ACCUM, all cnt=0, class_id=0, max_count=0, class_vld=0, no_spike=0, drop_err=0, scan index=0.
REQ-027 Reset asserted mid-SCAN SHALL abort the scan with no class_vld; after release the block SHALL be in ACCUM with cleared counters.

Verification
REQ-028 Three steps spike_in=10'b0000001000, then 10'b0000001001, then img_done -> class_vld at img_done+11, class_id=3, max_count=2, no_spike=0.
REQ-029 Equal counts: cnt[2]=cnt[7]=5, others lower, img_done -> class_id=2, max_count=5.
REQ-030 70 steps spike_in=10'b1000000000 (CNT_W=6), img_done -> class_id=9, max_count=63 (saturated).
REQ-031 img_done with no spikes -> class_id=0, max_count=0, no_spike=1; following image counts start from 0.
REQ-032 spike_vld pulsed 3 cycles after img_done -> counts unchanged, drop_err=1 until rst=0; result equals run without the pulse.
REQ-033 rst=0 during SCAN cycle 4 -> no class_vld, all outputs 0; subsequent image classified correctly.
